// File: rtl/snake_body.sv
// Snake body store: ring buffer of segment coordinates, a serial self-collision
// check on each accepted head move, and a registered occupancy lookup for display.
module snake_body #(
  parameter int MAX_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move,
  input  logic [3:0] head_x,
  input  logic [3:0] head_y,
  input  logic [3:0] food_x,
  input  logic [3:0] food_y,
  input  logic [3:0] qx,
  input  logic [3:0] qy,
  output logic       occupied,
  output logic [4:0] length,
  output logic       ate,
  output logic       busy,
  output logic       game_over
);

  localparam int PW = $clog2(MAX_LEN);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] OVER  = 2'd2;

  logic [1:0]    state;
  logic [7:0]    seg [MAX_LEN];
  logic [PW-1:0] wp;
  logic [PW-1:0] wp_nxt;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    head_l;
  logic          eat_l;
  logic [4:0]    idx_i;
  logic [4:0]    n_chk;
  logic [4:0]    last_i;
  logic          last;
  logic          hit;
  logic          accept;
  logic          q_hit_p0;

  // Distance from pointer a back to pointer b around the ring.
  function automatic int wrap_sub(input int a, input int b);
    int d;
    d = a - b;
    if (d < 0) d = d + MAX_LEN;
    return d;
  endfunction

  // Without eating, the tail cell vacates this move, so it is not compared.
  always_comb begin
    n_chk  = eat_l ? length : length - 5'd1;
    last_i = (n_chk == 5'd0) ? 5'd0 : n_chk - 5'd1;
    last   = (idx_i == last_i);
    rd_ptr = PW'(wrap_sub(int'(wp), int'(idx_i)));
    hit    = (idx_i < n_chk) && (seg[rd_ptr] == head_l);
    accept = (state == CHECK) && last && !hit;
    wp_nxt = (int'(wp) == MAX_LEN - 1) ? '0 : wp + PW'(1);
  end

  assign ate       = accept && eat_l;
  assign busy      = (state == CHECK);
  assign game_over = (state == OVER);

  // Occupancy lookup: an entry is live when its age behind wp is below length.
  always_comb begin
    q_hit_p0 = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((seg[k] == {qx, qy}) && (wrap_sub(int'(wp), k) < int'(length)))
        q_hit_p0 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      wp       <= '0;
      length   <= 5'd1;
      head_l   <= '0;
      eat_l    <= 1'b0;
      idx_i    <= '0;
      occupied <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) seg[k] <= '0;
    end else begin
      occupied <= q_hit_p0;
      case (state)
        RUN: begin
          if (move && ({head_x, head_y} != seg[wp])) begin
            head_l <= {head_x, head_y};
            eat_l  <= ({head_x, head_y} == {food_x, food_y});
            idx_i  <= '0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            state <= OVER;
          end else if (last) begin
            wp          <= wp_nxt;
            seg[wp_nxt] <= head_l;
            if (eat_l && (length < 5'(MAX_LEN))) length <= length + 5'd1;
            state       <= RUN;
          end else begin
            idx_i <= idx_i + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: table of move vectors with expected outcomes queued on a
// scoreboard, occupancy query table, plus growth-to-full and reset-mid-check sequences.
module tb_snake_body;
  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       move = 1'b0;
  logic [3:0] head_x = '0, head_y = '0, food_x = '0, food_y = '0, qx = '0, qy = '0;
  logic       occupied;
  logic [4:0] length;
  logic       ate, busy, game_over;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit rst;
    int hx, hy, fx, fy;
    int busy_c, ate_c, len;
    bit over;
  } mv_t;

  typedef struct {
    int after;
    int x, y;
    bit exp;
  } q_t;

  typedef struct {
    int busy_c, ate_c, len;
    bit over;
  } exp_t;

  exp_t sb[$];
  mv_t  tbl[13];
  q_t   qtbl[12];

  snake_body #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .reset(reset), .move(move),
    .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
    .qx(qx), .qy(qy),
    .occupied(occupied), .length(length), .ate(ate), .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic mv_t mk(bit r, int hx, int hy, int fx, int fy, int b, int a, int l, bit o);
    mv_t m;
    m.rst = r; m.hx = hx; m.hy = hy; m.fx = fx; m.fy = fy;
    m.busy_c = b; m.ate_c = a; m.len = l; m.over = o;
    return m;
  endfunction

  function automatic q_t mq(int after, int x, int y, bit e);
    q_t q;
    q.after = after; q.x = x; q.y = y; q.exp = e;
    return q;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_length"}, int'(length), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_ate"}, int'(ate), 0);
    check({tag, "_game_over"}, int'(game_over), 0);
    check({tag, "_occupied"}, int'(occupied), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    move  = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic apply_move(input string name, input int hx, input int hy, input int fx,
                            input int fy, input int b, input int a, input int l, input bit o);
    exp_t e;
    int   cnt;
    int   atec;
    e.busy_c = b; e.ate_c = a; e.len = l; e.over = o;
    sb.push_back(e);
    @(negedge clk);
    head_x = 4'(hx); head_y = 4'(hy);
    food_x = 4'(fx); food_y = 4'(fy);
    move   = 1'b1;
    @(negedge clk);
    move = 1'b0;
    cnt  = 0;
    atec = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (ate) atec++;
      @(negedge clk);
    end
    if (ate) atec++;
    e = sb.pop_front();
    check({name, "_busy_cycles"}, cnt, e.busy_c);
    check({name, "_ate_pulses"}, atec, e.ate_c);
    check({name, "_length"}, int'(length), e.len);
    check({name, "_game_over"}, int'(game_over), int'(e.over));
  endtask

  task automatic query(input string name, input int x, input int y, input bit e);
    @(negedge clk);
    qx = 4'(x); qy = 4'(y);
    @(negedge clk);
    check(name, int'(occupied), int'(e));
  endtask

  initial begin
    // A: plain move from reset
    tbl[0]  = mk(1, 1, 0, 5, 5, 1, 0, 1, 0);
    // B: eat on first move
    tbl[1]  = mk(1, 1, 0, 1, 0, 1, 1, 2, 0);
    // C: grow, then collide with the tail while eating, then ignored move
    tbl[2]  = mk(1, 1, 0, 1, 0, 1, 1, 2, 0);
    tbl[3]  = mk(0, 2, 0, 2, 0, 2, 1, 3, 0);
    tbl[4]  = mk(0, 2, 1, 2, 1, 3, 1, 4, 0);
    tbl[5]  = mk(0, 1, 1, 9, 9, 3, 0, 4, 0);
    tbl[6]  = mk(0, 1, 0, 1, 0, 4, 0, 4, 1);
    tbl[7]  = mk(0, 3, 3, 9, 9, 0, 0, 4, 1);
    // D: move into vacating tail, then repeated same-position strobes
    tbl[8]  = mk(1, 1, 0, 1, 0, 1, 1, 2, 0);
    tbl[9]  = mk(0, 2, 0, 2, 0, 2, 1, 3, 0);
    tbl[10] = mk(0, 0, 0, 9, 9, 2, 0, 3, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 3, 0);
    tbl[12] = mk(0, 0, 0, 9, 9, 0, 0, 3, 0);

    qtbl[0]  = mq(0, 0, 0, 0);
    qtbl[1]  = mq(0, 1, 0, 1);
    qtbl[2]  = mq(1, 0, 0, 1);
    qtbl[3]  = mq(1, 1, 0, 1);
    qtbl[4]  = mq(5, 1, 0, 1);
    qtbl[5]  = mq(5, 0, 0, 0);
    qtbl[6]  = mq(7, 1, 1, 1);
    qtbl[7]  = mq(12, 0, 0, 1);
    qtbl[8]  = mq(12, 2, 0, 1);
    qtbl[9]  = mq(12, 1, 0, 1);
    qtbl[10] = mq(12, 3, 0, 0);
    qtbl[11] = mq(12, 2, 1, 0);

    repeat (2) @(negedge clk);

    for (int r = 0; r < 13; r++) begin
      if (tbl[r].rst) do_reset();
      apply_move($sformatf("vec%0d", r), tbl[r].hx, tbl[r].hy, tbl[r].fx, tbl[r].fy,
                 tbl[r].busy_c, tbl[r].ate_c, tbl[r].len, tbl[r].over);
      for (int q = 0; q < 12; q++) begin
        if (qtbl[q].after == r)
          query($sformatf("occ_q%0d", q), qtbl[q].x, qtbl[q].y, qtbl[q].exp);
      end
    end

    // Grow to full length along row y=0, eat once more at full length, then wrap
    do_reset();
    for (int k = 1; k < MAX_LEN; k++)
      apply_move($sformatf("grow%0d", k), k, 0, k, 0, k, 1, k + 1, 0);
    apply_move("eat_full", 15, 1, 15, 1, 16, 1, 16, 0);
    query("full_occ_00", 0, 0, 0);
    query("full_occ_151", 15, 1, 1);
    query("full_occ_10", 1, 0, 1);
    query("full_occ_80", 8, 0, 1);
    apply_move("full_step", 14, 1, 9, 9, 15, 0, 16, 0);
    query("wrap_occ_10", 1, 0, 0);
    query("wrap_occ_20", 2, 0, 1);
    query("wrap_occ_141", 14, 1, 1);

    // Reset asserted while a check is in progress
    do_reset();
    apply_move("pre_a", 1, 0, 1, 0, 1, 1, 2, 0);
    apply_move("pre_b", 2, 0, 2, 0, 2, 1, 3, 0);
    query("occ_pre_rst", 2, 0, 1);
    @(negedge clk);
    head_x = 4'd3; head_y = 4'd0; food_x = 4'd3; food_y = 4'd0;
    move = 1'b1;
    @(negedge clk);
    move = 1'b0;
    check("busy_mid_check", int'(busy), 1);
    reset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(negedge clk);
    check_reset_vals("mid_rst_hold");
    reset = 1'b1;
    apply_move("post_rst", 1, 0, 5, 5, 1, 0, 1, 0);
    query("post_occ_10", 1, 0, 1);
    query("post_occ_20", 2, 0, 0);
    query("post_occ_30", 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
